// File: rtl/bcd_countdown_timer_if.sv
// Keypad/control requests into the countdown timer and its display/status back out.
// master = controller side, slave = timer side.
interface bcd_countdown_timer_if #(
   parameter int MIN_DIGITS = 2
);
   localparam int N = MIN_DIGITS + 2;

   logic           loadn;
   logic [3:0]     data;
   logic           startn;
   logic           stopn;
   logic [4*N-1:0] digits;
   logic           running;
   logic           zero;
   logic           done;

   modport master (
      output loadn, data, startn, stopn,
      input  digits, running, zero, done
   );

   modport slave (
      input  loadn, data, startn, stopn,
      output digits, running, zero, done
   );
endinterface

// File: rtl/bcd_countdown_timer.sv
// BCD mm:ss countdown with shift-in entry, pause/resume/cancel and a done pulse at 00:00.
// Registered outputs one edge after the request (zero is combinational); no backpressure, requests sampled every edge.
module bcd_countdown_timer #(
   parameter int MIN_DIGITS = 2,
   parameter int TICK_DIV   = 50_000_000
) (
   input  logic                 clk,
   input  logic                 clrn,
   bcd_countdown_timer_if.slave bus
);
   localparam int N  = MIN_DIGITS + 2;
   localparam int W  = 4 * N;
   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  digits_q, digits_d;
   logic [W-1:0]  dec_val, shift_val;
   logic [PW-1:0] presc_q, presc_d;
   logic          running_q, done_q;
   logic          load_ok, zero_w, tick, advance;

   assign load_ok   = !bus.loadn && (bus.data <= 4'd9);
   assign shift_val = {digits_q[W-5:0], bus.data};
   assign zero_w    = (digits_q == '0);
   assign tick      = (presc_q == PMAX);

   // One-second decrement: seconds tens borrows to 5, every other digit to 9.
   // Tens values 6-9 left by entry simply count down until they reach 0.
   always_comb begin
      logic borrow;
      dec_val = digits_q;
      borrow  = 1'b1;
      for (int i = 0; i < N; i++) begin
         if (borrow) begin
            if (digits_q[4*i +: 4] == 4'd0) begin
               dec_val[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
            end else begin
               dec_val[4*i +: 4] = digits_q[4*i +: 4] - 4'd1;
               borrow            = 1'b0;
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      presc_d  = presc_q;
      advance  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.stopn) begin
               digits_d = '0;
            end else if (!bus.startn && !zero_w) begin
               state_d = RUN;
               presc_d = '0;
            end else if (load_ok) begin
               digits_d = shift_val;
            end
         end
         RUN: begin
            if (!bus.stopn) state_d = PAUSE;
            else            advance = 1'b1;
         end
         PAUSE: begin
            if (!bus.stopn) begin
               state_d  = IDLE;
               digits_d = '0;
            end else if (!bus.startn) begin
               advance = 1'b1;
            end
         end
         DONE: begin
            if (!bus.stopn) begin
               state_d  = IDLE;
               digits_d = '0;
            end else if (load_ok) begin
               state_d  = IDLE;
               digits_d = shift_val;
            end
         end
         default: state_d = IDLE;
      endcase

      // The resume edge counts toward the current second, so the prescaler picks up where it left off.
      if (advance) begin
         if (tick) begin
            presc_d  = '0;
            digits_d = dec_val;
            state_d  = (dec_val == '0) ? DONE : RUN;
         end else begin
            presc_d = presc_q + 1'b1;
            state_d = RUN;
         end
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q   <= IDLE;
         digits_q  <= '0;
         presc_q   <= '0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         digits_q  <= digits_d;
         presc_q   <= presc_d;
         running_q <= (state_d == RUN);
         done_q    <= (state_d == DONE) && (state_q != DONE);
      end
   end

   assign bus.digits  = digits_q;
   assign bus.running = running_q;
   assign bus.zero    = zero_w;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench: a seconds/minutes arithmetic model predicts every cycle's outputs,
// a monitor pops and compares after each rising edge; directed timing checks plus random traffic.
module tb_bcd_countdown_timer;
   localparam int MIN_DIGITS = 2;
   localparam int TICK_DIV   = 4;
   localparam int N          = MIN_DIGITS + 2;
   localparam int W          = 4 * N;
   localparam int MOD        = 10 ** N;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   typedef struct packed {
      logic [W-1:0] digits;
      logic         running;
      logic         zero;
      logic         done;
   } obs_t;

   logic clk = 1'b0;
   logic clrn;
   obs_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_mode, m_val, m_presc;
   bit   m_done;

   bcd_countdown_timer_if #(.MIN_DIGITS(MIN_DIGITS)) bus ();

   bcd_countdown_timer #(.MIN_DIGITS(MIN_DIGITS), .TICK_DIV(TICK_DIV)) dut (
      .clk (clk),
      .clrn(clrn),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] to_bcd(int v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         r[4*i +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Time is held as minutes*100 + seconds; seconds may be 60..99 after entry.
   task automatic count_step();
      if (m_presc == TICK_DIV - 1) begin
         m_presc = 0;
         if (m_val % 100 > 0) m_val = m_val - 1;
         else                 m_val = (m_val / 100 - 1) * 100 + 59;
         if (m_val == 0) begin
            m_mode = M_DONE;
            m_done = 1'b1;
         end else begin
            m_mode = M_RUN;
         end
      end else begin
         m_presc = m_presc + 1;
         m_mode  = M_RUN;
      end
   endtask

   task automatic model_step(input bit ld, input int d, input bit st, input bit sp);
      m_done = 1'b0;
      case (m_mode)
         M_IDLE:  if (sp) m_val = 0;
                  else if (st && m_val != 0) begin m_mode = M_RUN; m_presc = 0; end
                  else if (ld && d <= 9) m_val = (m_val * 10 + d) % MOD;
         M_RUN:   if (sp) m_mode = M_PAUSE; else count_step();
         M_PAUSE: if (sp) begin m_mode = M_IDLE; m_val = 0; end
                  else if (st) count_step();
         default: if (sp) m_mode = M_IDLE;
                  else if (ld && d <= 9) begin m_mode = M_IDLE; m_val = d; end
      endcase
   endtask

   task automatic push_exp();
      obs_t e;
      e.digits  = to_bcd(m_val);
      e.running = (m_mode == M_RUN);
      e.zero    = (m_val == 0);
      e.done    = m_done;
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_val = 0; m_presc = 0; m_done = 1'b0;
   endtask

   task automatic cyc(input bit ld, input logic [3:0] d, input bit st, input bit sp);
      @(negedge clk);
      clrn       = 1'b1;
      bus.loadn  = !ld;
      bus.data   = d;
      bus.startn = !st;
      bus.stopn  = !sp;
      model_step(ld, int'(d), st, sp);
      push_exp();
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [3:0] d);
      cyc(1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.loadn = 1'b1; bus.startn = 1'b1; bus.stopn = 1'b1; bus.data = 4'd0;
      clrn = 1'b0;
      #1;
      chk("reset_digits", 32'(bus.digits), 32'h0);
      chk("reset_zero", 32'(bus.zero), 32'h1);
      chk("reset_running", 32'(bus.running), 32'h0);
      chk("reset_done", 32'(bus.done), 32'h0);
      model_reset();
      push_exp();
   endtask

   initial begin : monitor
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {bus.digits, bus.running, bus.zero, bus.done};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL scoreboard @%0t: got digits=%h running=%b zero=%b done=%b, want digits=%h running=%b zero=%b done=%b",
                        $time, a.digits, a.running, a.zero, a.done, e.digits, e.running, e.zero, e.done);
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stimulus
      int r;
      logic [3:0] rd;
      clrn = 1'b1;
      bus.loadn = 1'b1; bus.startn = 1'b1; bus.stopn = 1'b1; bus.data = 4'd0;
      #1 clrn = 1'b0;
      #1;
      chk("init_digits", 32'(bus.digits), 32'h0);
      chk("init_zero", 32'(bus.zero), 32'h1);
      chk("init_running", 32'(bus.running), 32'h0);
      chk("init_done", 32'(bus.done), 32'h0);
      model_reset();
      push_exp();

      // Shift-in entry, invalid digit ignored, top digit dropped.
      load(4'd1); load(4'd3); load(4'd0); settle();
      chk("entry_0130", 32'(bus.digits), 32'h0130);
      load(4'hA); settle();
      chk("entry_hex_ignored", 32'(bus.digits), 32'h0130);
      load(4'd5); settle();
      chk("entry_1305", 32'(bus.digits), 32'h1305);
      cyc(1'b0, 4'd0, 1'b0, 1'b1);

      // 01:30 countdown timing from the start edge E.
      load(4'd1); load(4'd3); load(4'd0);
      cyc(1'b0, 4'd0, 1'b1, 1'b0); settle();
      chk("start_running", 32'(bus.running), 32'h1);
      idle(4); settle();
      chk("cd_e4_0129", 32'(bus.digits), 32'h0129);
      idle(120); settle();
      chk("cd_e124_0059", 32'(bus.digits), 32'h0059);
      idle(236); settle();
      chk("cd_e360_zero", 32'(bus.digits), 32'h0);
      chk("cd_e360_done", 32'(bus.done), 32'h1);
      chk("cd_e360_running", 32'(bus.running), 32'h0);
      idle(1); settle();
      chk("cd_done_one_cycle", 32'(bus.done), 32'h0);

      // 00:90 counts through the 60s before any tens wrap.
      load(4'd9); load(4'd0); settle();
      chk("mixed_0090", 32'(bus.digits), 32'h0090);
      cyc(1'b0, 4'd0, 1'b1, 1'b0);
      idle(120); settle();
      chk("mixed_0060", 32'(bus.digits), 32'h0060);
      idle(4); settle();
      chk("mixed_0059", 32'(bus.digits), 32'h0059);

      // Pause two cycles after a tick, hold, then resume.
      idle(1);
      cyc(1'b0, 4'd0, 1'b0, 1'b1); settle();
      chk("pause_running", 32'(bus.running), 32'h0);
      idle(10); settle();
      chk("pause_hold", 32'(bus.digits), 32'h0059);
      cyc(1'b0, 4'd0, 1'b1, 1'b0); settle();
      chk("resume_running", 32'(bus.running), 32'h1);
      idle(1); settle();
      chk("resume_r1", 32'(bus.digits), 32'h0059);
      idle(1); settle();
      chk("resume_r2_0058", 32'(bus.digits), 32'h0058);
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b0, 1'b1); settle();
      chk("cancel_digits", 32'(bus.digits), 32'h0);
      chk("cancel_running", 32'(bus.running), 32'h0);

      // Start on zero is ignored; stop beats start in PAUSE; load from DONE.
      cyc(1'b0, 4'd0, 1'b1, 1'b0); settle();
      chk("start_on_zero", 32'(bus.running), 32'h0);
      load(4'd7);
      cyc(1'b0, 4'd0, 1'b1, 1'b0);
      idle(2);
      cyc(1'b0, 4'd0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b1, 1'b1); settle();
      chk("pause_stop_start", 32'(bus.digits), 32'h0);
      load(4'd2);
      cyc(1'b0, 4'd0, 1'b1, 1'b0);
      idle(8); settle();
      chk("short_done", 32'(bus.done), 32'h1);
      load(4'd3); settle();
      chk("done_load_digits", 32'(bus.digits), 32'h0003);
      chk("done_load_idle", 32'(bus.running), 32'h0);

      // Reset in the middle of a run.
      load(4'd4);
      cyc(1'b0, 4'd0, 1'b1, 1'b0);
      idle(3);
      do_reset();
      idle(5); settle();
      chk("post_reset_idle", 32'(bus.running), 32'h0);

      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(0, 999);
         rd = 4'($urandom_range(0, 15));
         if (r < 4) begin
            do_reset();
         end else if (r < 14) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b1);
            load(4'($urandom_range(1, 9)));
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
         end else if (r < 40) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b1);
         end else if (r < 80) begin
            cyc(1'b0, 4'd0, 1'b1, 1'b0);
         end else if (r < 90) begin
            cyc(1'b0, 4'd0, 1'b1, 1'b1);
         end else if (r < 300) begin
            load(rd);
         end else if (r < 320) begin
            cyc(1'b1, rd, 1'b1, 1'b0);
         end else begin
            idle(1);
         end
      end

      idle(2); settle();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
